// File: rtl/tick_div_pkg.sv
// Shared types and helpers for the multi-channel tick divider.
// Holds the channel state encoding, the default reset divisor and the divisor clamp.
package tick_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // One second at a 50 MHz board clock.
  localparam int unsigned DEFAULT_RESET_DIV = 32'd50_000_000;

  // Widest counter the clamp helper supports; callers zero-extend into it.
  localparam int DIV_MAX_W = 64;

  // A divisor of zero would never wrap, so it is stored as one.
  function automatic logic [DIV_MAX_W-1:0] clamp_min1(input logic [DIV_MAX_W-1:0] x);
    return (x == '0) ? DIV_MAX_W'(1) : x;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, active/pending divisor and the IDLE/RUN state machine.
// Produces a registered single-cycle tick when the count reaches the active divisor.
module tick_channel
  import tick_div_pkg::*;
#(
  parameter int             CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_RESET_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             oneshot,
  input  logic             start,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RESET_DIV_CLAMPED =
    CNT_W'(clamp_min1(DIV_MAX_W'(RESET_DIV)));

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] wr_div_clamped;
  logic             wrap;

  assign wr_div_clamped = CNT_W'(clamp_min1(DIV_MAX_W'(wr_div)));
  // >= rather than == so a count left above a shrunken divisor still wraps.
  assign wrap           = (cnt_q >= (div_act_q - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_vld_q) begin
          div_act_d  = div_pend_q;
          pend_vld_d = 1'b0;
        end
        if (en && (!oneshot || start)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (oneshot && start) begin
          cnt_d = '0;
        end else if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (pend_vld_q) begin
            div_act_d  = div_pend_q;
            pend_vld_d = 1'b0;
          end
          if (oneshot) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A write landing on a wrap keeps the old divisor and waits for the next wrap.
    if (wr_en) begin
      if (state_q == RUN) begin
        div_act_d  = div_act_q;
        div_pend_d = wr_div_clamped;
        pend_vld_d = 1'b1;
      end else begin
        div_act_d  = wr_div_clamped;
        pend_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_act_q  <= RESET_DIV_CLAMPED;
      div_pend_q <= '0;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;
  assign busy = (state_q == RUN);

endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel tick generator: NUM_CH independent programmable dividers on one clock.
// The top only decodes divisor writes and replicates the channel.
module multi_tick_divider
  import tick_div_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int unsigned RESET_DIV = DEFAULT_RESET_DIV,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Indices at or above NUM_CH match no channel, so such writes are dropped.
      assign wr_en[gi] = cfg_we && (cfg_ch == CH_W'(gi));

      tick_channel #(
        .CNT_W    (CNT_W),
        .RESET_DIV(CNT_W'(RESET_DIV))
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .en     (en[gi]),
        .oneshot(oneshot[gi]),
        .start  (start[gi]),
        .wr_en  (wr_en[gi]),
        .wr_div (cfg_div),
        .tick   (tick[gi]),
        .busy   (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_tick_divider.sv
// Self-checking bench for multi_tick_divider: directed scenarios then random traffic,
// compared each edge against a reference that tracks the edge number of each channel's next tick.
module tb_multi_tick_divider;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int RD = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] en, oneshot, start;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [W-1:0] cfg_div;
  logic [N-1:0] tick, busy;

  always #5 clk = ~clk;

  multi_tick_divider #(.NUM_CH(N), .CNT_W(W), .RESET_DIV(RD)) dut (
    .clk(clk), .rst(rst), .en(en), .oneshot(oneshot), .start(start),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick), .busy(busy)
  );

  int     vectors     = 0;
  int     miscompares = 0;
  longint edge_no     = 0;

  // Reference: a running channel knows its period and the edge at which it next ticks.
  bit     m_run [N];
  int     m_per [N];
  int     m_pend[N];
  bit     m_pv  [N];
  longint m_due [N];
  logic [N-1:0] exp_tick, exp_busy;

  int     tick_cnt  [N];
  longint first_tick[N];

  function automatic int clampv(int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_run[c] = 1'b0; m_per[c] = RD; m_pend[c] = 0; m_pv[c] = 1'b0; m_due[c] = 0;
    end
    exp_tick = '0;
    exp_busy = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      bit was_run;
      bit wrote;
      int v;
      was_run     = m_run[c];
      wrote       = 1'b0;
      exp_tick[c] = 1'b0;
      if (cfg_we && (int'(cfg_ch) == c)) begin
        v = clampv(int'(cfg_div));
        if (was_run) begin
          m_pend[c] = v; m_pv[c] = 1'b1; wrote = 1'b1;
        end else begin
          m_per[c] = v; m_pv[c] = 1'b0;
        end
      end
      if (!en[c]) begin
        m_run[c] = 1'b0;
      end else if (was_run && oneshot[c] && start[c]) begin
        m_due[c] = edge_no + m_per[c];
      end else if (was_run && edge_no == m_due[c]) begin
        exp_tick[c] = 1'b1;
        if (m_pv[c] && !wrote) begin
          m_per[c] = m_pend[c]; m_pv[c] = 1'b0;
        end
        if (oneshot[c]) m_run[c] = 1'b0;
        else            m_due[c] = edge_no + m_per[c];
      end else if (!was_run && (!oneshot[c] || start[c])) begin
        m_run[c] = 1'b1;
        m_due[c] = edge_no + m_per[c];
      end
      if (!m_run[c] && m_pv[c]) begin
        m_per[c] = m_pend[c]; m_pv[c] = 1'b0;
      end
      exp_busy[c] = m_run[c];
    end
  endtask

  task automatic clr_obs();
    for (int c = 0; c < N; c++) begin
      tick_cnt[c]   = 0;
      first_tick[c] = -1;
    end
  endtask

  task automatic check_eq(string tag, longint got, longint want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < N; c++) begin
      vectors++;
      assert (tick[c] === exp_tick[c]) else begin
        miscompares++;
        $error("FAIL tick ch%0d edge %0d: got %b want %b", c, edge_no, tick[c], exp_tick[c]);
      end
      vectors++;
      assert (busy[c] === exp_busy[c]) else begin
        miscompares++;
        $error("FAIL busy ch%0d edge %0d: got %b want %b", c, edge_no, busy[c], exp_busy[c]);
      end
      if (tick[c] === 1'b1) begin
        tick_cnt[c]++;
        if (first_tick[c] < 0) first_tick[c] = edge_no;
      end
    end
    $display("edge %0d rst=%b en=%b os=%b st=%b we=%b ch=%0d div=%0d tick=%b busy=%b",
             edge_no, rst, en, oneshot, start, cfg_we, cfg_ch, cfg_div, tick, busy);
    edge_no++;
    start  = '0;
    cfg_we = 1'b0;
  endtask

  task automatic write_div(int ch, int d);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = W'(d);
  endtask

  longint base;

  initial begin
    rst = 1'b1; en = '0; oneshot = '0; start = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    model_reset();
    clr_obs();
    repeat (2) step();
    check_eq("reset tick", longint'(tick), 0);
    check_eq("reset busy", longint'(busy), 0);
    rst = 1'b0;

    // Reset divisor 5, ch0 periodic: ticks at 5, 10, 15.
    en = 4'b0001;
    clr_obs(); base = edge_no;
    repeat (16) step();
    check_eq("ch0 tick count", tick_cnt[0], 3);
    check_eq("ch0 first tick", first_tick[0] - base, 5);
    check_eq("ch1-3 silent", tick_cnt[1] + tick_cnt[2] + tick_cnt[3], 0);

    // ch1 one-shot D=3.
    write_div(1, 3); step();
    oneshot[1] = 1'b1; en[1] = 1'b1; start[1] = 1'b1;
    clr_obs(); base = edge_no;
    repeat (10) step();
    check_eq("ch1 oneshot count", tick_cnt[1], 1);
    check_eq("ch1 oneshot edge", first_tick[1] - base, 3);

    // ch0 D=5, write 2 at cycle 7: ticks 5, 10, 12, 14.
    en[0] = 1'b0; step();
    write_div(0, 5); step();
    en[0] = 1'b1;
    clr_obs(); base = edge_no;
    repeat (7) step();
    write_div(0, 2); step();
    repeat (8) step();
    check_eq("ch0 retime count", tick_cnt[0], 4);

    // ch2 divisor 0 clamps to 1: continuous tick.
    write_div(2, 0); step();
    en[2] = 1'b1;
    clr_obs(); base = edge_no;
    repeat (10) step();
    check_eq("ch2 clamp count", tick_cnt[2], 9);

    // ch3 one-shot D=8 restarted at cycle 4: single tick at 12.
    write_div(3, 8); en[3] = 1'b1; oneshot[3] = 1'b1; step();
    start[3] = 1'b1;
    clr_obs(); base = edge_no;
    repeat (4) step();
    start[3] = 1'b1;
    repeat (12) step();
    check_eq("ch3 restart count", tick_cnt[3], 1);
    check_eq("ch3 restart edge", first_tick[3] - base, 12);

    // Reset mid-count restores the reset divisor (3 written before is lost).
    en = '0; oneshot = '0; step();
    write_div(0, 3); step();
    en = 4'b0001;
    base = edge_no;
    repeat (4) step();
    rst = 1'b1;
    #1;
    check_eq("async reset tick", longint'(tick), 0);
    check_eq("async reset busy", longint'(busy), 0);
    repeat (2) step();
    rst = 1'b0;
    clr_obs();
    repeat (11) step();
    check_eq("post-reset first tick", first_tick[0] - base, 11);

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 31) == 0) oneshot[c] = ~oneshot[c];
        start[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 5) == 0) write_div(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
